jedro_1_fetch_buf: RTL and testbench

//  Instruction fetch stage of the jedro_1 core. Sits between the synchronous instruction ROM
//  (1-cycle read latency) and the decoder. Keeps a program counter and issues sequential word

---
 rtl/jedro_1_fetch_buf_pkg.sv | 11 +
 rtl/jedro_1_fetch_buf_if.sv | 24 ++
 rtl/jedro_1_fetch_buf_sync_fifo.sv | 46 ++++
 rtl/jedro_1_fetch_buf.sv | 63 ++++++
 tb/tb_jedro_1_fetch_buf.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/jedro_1_fetch_buf_pkg.sv
// Shared widths, boot address and the prefetch entry layout for the jedro_1 fetch stage.
package jedro_1_defines;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] BOOT_ADDR = 32'h0000_0000;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/jedro_1_fetch_buf_if.sv
// Fetch-stage bus: ROM read port on one side, decoder valid/ready + redirect on the other.
interface jedro_1_fetch_buf_if;
  import jedro_1_defines::*;

  logic                  imem_en_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic                  jmp_i;
  logic [ADDR_WIDTH-1:0] jmp_addr_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (
    output imem_en_o, imem_addr_o, instr_o, pc_o, valid_o,
    input  imem_rdata_i, jmp_i, jmp_addr_i, ready_i
  );

  modport slave (
    input  imem_en_o, imem_addr_o, instr_o, pc_o, valid_o,
    output imem_rdata_i, jmp_i, jmp_addr_i, ready_i
  );
endinterface

// File: rtl/jedro_1_fetch_buf_sync_fifo.sv
// Show-ahead synchronous FIFO with a one-cycle flush; the caller guarantees no overflow/underflow.
module jedro_1_sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = jedro_1_defines::fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PONE = 1;
  localparam logic [PW:0]   CONE = 1;

  T              mem [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= din;
  end

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PONE;
      if (pop)  rp_q <= rp_q + PONE;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CONE;
        2'b01:   cnt_q <= cnt_q - CONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout  = mem[rp_q];
  assign count = cnt_q;
endmodule

// File: rtl/jedro_1_fetch_buf.sv
// jedro_1 fetch stage: PC, credit-limited ROM issue, one-deep in-flight tracking and prefetch FIFO.
module jedro_1_fetch_buf #(
  parameter int                                      DEPTH     = 4,
  parameter logic [jedro_1_defines::ADDR_WIDTH-1:0]  BOOT_ADDR = jedro_1_defines::BOOT_ADDR
) (
  input  logic                clk_i,
  input  logic                rst_i,
  jedro_1_fetch_buf_if.master bus
);
  import jedro_1_defines::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]           DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WORD    = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] pc_q, iss_addr_q, addr;
  logic                  inflight_q, issue, push, pop;
  logic [CW-1:0]         count;
  logic [CW:0]           used;
  fetch_entry_t          wr_entry, head;

  // Outstanding credit counts the in-flight read so a full FIFO can never be overrun.
  assign used  = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue = !rst_i && (bus.jmp_i || (used < DEPTH_C));
  assign addr  = bus.jmp_i ? {bus.jmp_addr_i[ADDR_WIDTH-1:2], 2'b00} : pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= BOOT_ADDR;
      inflight_q <= 1'b0;
      iss_addr_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q       <= addr + WORD;
        iss_addr_q <= addr;
      end
    end
  end

  // A redirect discards the response of the previous issue and blocks the decoder handshake.
  assign push           = inflight_q && !bus.jmp_i && !rst_i;
  assign bus.valid_o    = (count != '0) && !bus.jmp_i && !rst_i;
  assign pop            = bus.valid_o && bus.ready_i;
  assign wr_entry.instr = bus.imem_rdata_i;
  assign wr_entry.pc    = iss_addr_q;

  jedro_1_sync_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (bus.jmp_i),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .count (count)
  );

  assign bus.imem_en_o   = issue;
  assign bus.imem_addr_o = addr;
  assign bus.instr_o     = rst_i ? '0 : head.instr;
  assign bus.pc_o        = rst_i ? '0 : head.pc;
endmodule

// File: tb/tb_jedro_1_fetch_buf.sv
// Directed bench for jedro_1_fetch_buf: per-cycle vector table plus a stall/drain scoreboard sequence.
module tb_jedro_1_fetch_buf;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jedro_1_fetch_buf_if bus ();

  jedro_1_fetch_buf #(.DEPTH(4), .BOOT_ADDR(32'h0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ROM with one-cycle latency: word i holds i.
  always @(posedge clk) begin
    if (bus.imem_en_o) bus.imem_rdata_i <= bus.imem_addr_o >> 2;
  end

  typedef struct {
    logic        rst, jmp, rdy;
    logic [31:0] jaddr;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic j, input logic [31:0] ja, input logic rd,
                     input logic en, input logic [31:0] ad, input logic v, input logic [31:0] pc);
    vec_t t;
    t.rst = r; t.jmp = j; t.jaddr = ja; t.rdy = rd;
    t.en = en; t.addr = ad; t.vld = v; t.pc = pc;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic j, input logic [31:0] ja, input logic rd);
    rst = r; bus.jmp_i = j; bus.jmp_addr_i = ja; bus.ready_i = rd;
  endtask

  logic [31:0] exp_pc;
  int          got;

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    bus.imem_rdata_i = '0;

    // reset, then sequential stream from BOOT_ADDR
    add(1,0,0,1, 0,0,      0,0);
    add(1,0,0,1, 0,0,      0,0);
    add(0,0,0,1, 1,32'h0,  0,0);
    add(0,0,0,1, 1,32'h4,  0,0);
    for (int k = 2; k < 6; k++) add(0,0,0,1, 1,32'(4*k), 1,32'(4*(k-2)));
    // decoder stalls 10 cycles: issue stops once count+inflight hits 4
    add(0,0,0,0, 1,32'd24, 1,32'd16);
    add(0,0,0,0, 1,32'd28, 1,32'd16);
    for (int k = 0; k < 8; k++) add(0,0,0,0, 0,0, 1,32'd16);
    add(0,0,0,1, 0,0,      1,32'd16);
    add(0,0,0,1, 1,32'd32, 1,32'd20);
    add(0,0,0,1, 1,32'd36, 1,32'd24);
    // jump with entries buffered
    add(0,1,32'h40,1, 1,32'h40, 0,0);
    add(0,0,0,1,      1,32'h44, 0,0);
    add(0,0,0,1,      1,32'h48, 1,32'h40);
    add(0,0,0,1,      1,32'h4c, 1,32'h44);
    // back-to-back jumps, misaligned target
    add(0,1,32'h80,1,  1,32'h80,  0,0);
    add(0,1,32'h103,1, 1,32'h100, 0,0);
    add(0,0,0,1,       1,32'h104, 0,0);
    add(0,0,0,1,       1,32'h108, 1,32'h100);
    add(0,0,0,1,       1,32'h10c, 1,32'h104);
    // address wrap at the top of the space
    add(0,1,32'hffff_fff8,1, 1,32'hffff_fff8, 0,0);
    add(0,0,0,1, 1,32'hffff_fffc, 0,0);
    add(0,0,0,1, 1,32'h0, 1,32'hffff_fff8);
    add(0,0,0,1, 1,32'h4, 1,32'hffff_fffc);
    add(0,0,0,1, 1,32'h8, 1,32'h0);
    // one-cycle reset with a read in flight
    add(1,0,0,1, 0,0,     0,0);
    add(0,0,0,1, 1,32'h0, 0,0);
    add(0,0,0,1, 1,32'h4, 0,0);
    add(0,0,0,1, 1,32'h8, 1,32'h0);
    add(0,0,0,1, 1,32'hc, 1,32'h4);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].jmp, vecs[i].jaddr, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("v%0d en", i), 32'(bus.imem_en_o), 32'(vecs[i].en));
      if (vecs[i].en) chk($sformatf("v%0d addr", i), bus.imem_addr_o, vecs[i].addr);
      chk($sformatf("v%0d valid", i), 32'(bus.valid_o), 32'(vecs[i].vld));
      if (vecs[i].vld || vecs[i].rst) begin
        chk($sformatf("v%0d pc", i), bus.pc_o, vecs[i].pc);
        chk($sformatf("v%0d instr", i), bus.instr_o, vecs[i].pc >> 2);
      end
      @(posedge clk); #1;
    end

    // jump while decoder stalls, fill to capacity, then drain in order
    drive(1'b0, 1'b1, 32'h200, 1'b0);
    @(negedge clk);
    chk("seq jmp valid", 32'(bus.valid_o), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("seq full en", 32'(bus.imem_en_o), 32'd0);
    chk("seq full valid", 32'(bus.valid_o), 32'd1);
    chk("seq full pc", bus.pc_o, 32'h200);
    @(posedge clk); #1;
    bus.ready_i = 1'b1;
    exp_pc = 32'h200;
    got = 0;
    for (int c = 0; c < 12 && got < 8; c++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        chk($sformatf("drain%0d pc", got), bus.pc_o, exp_pc);
        chk($sformatf("drain%0d instr", got), bus.instr_o, exp_pc >> 2);
        exp_pc += 32'd4;
        got++;
      end
      @(posedge clk); #1;
    end
    chk("drain count", 32'(got), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
